ccl_labeler: RTL and testbench
==============================

Name: ccl_labeler

Overview:
- First-pass connected-component labeler for the motion-mask stream, directly upstream of the label merger.
- Assigns a provisional label to every foreground pixel in raster order.
- Emits one label-equivalence (merge) request per cycle into the merger's merge_valid/merge_a/merge_b port.
- Forwards labelled pixels with coordinates to the bounding-box stage.

Parameters:
- IMG_WIDTH, 320, pixels per row.
- IMG_HEIGHT, 240, rows per frame.
- LABEL_WIDTH, 8, label bits; label 0 = background; MAX_LABEL = 2^LABEL_WIDTH-1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  block enable; when low, pix_valid is ignored and all state holds.
- pix_valid  in  1  mask pixel present this cycle.
- pix_fg  in  1  1 = foreground (motion) pixel.
- frame_start  in  1  qualifies the first pixel of a frame; valid only with pix_valid.
- label_valid  out  1  labelled pixel output valid.
- label_out  out  LABEL_WIDTH  provisional label, 0 for background.
- label_x  out  $clog2(IMG_WIDTH)  column of label_out.
- label_y  out  $clog2(IMG_HEIGHT)  row of label_out.
- merge_valid  out  1  equivalence request to the label merger.
- merge_a  out  LABEL_WIDTH  larger label of the pair.
- merge_b  out  LABEL_WIDTH  smaller label of the pair.
- frame_done  out  1  one-cycle pulse, asserted with the last pixel's label_valid.
- num_labels  out  LABEL_WIDTH  labels allocated so far in the current frame.
- overflow  out  1  sticky: label space exhausted this frame.

Behaviour:
- Reset: all outputs 0; x=y=0; next_label=1; row_valid=0.
- Pixel acceptance: a pixel is accepted when enable && pix_valid.
- Latency: outputs are registered, 1 cycle after an accepted pixel. label_valid, label_x/y, merge_* and frame_done all appear in the same cycle.
- Bubbles: no backpressure. Cycles with no accepted pixel produce label_valid=0 and merge_valid=0, and x/y do not advance.
- Neighbourhood: W is the previous label this row. N, NW and NE come from a previous-row label line buffer.
  - W and NW read as 0 at x=0.
  - NE reads as 0 at x=IMG_WIDTH-1.
  - N, NE and NW read as 0 while row_valid=0 (row 0). The buffer is not cleared.
- Line buffer write: entry x is written with the current label, 0 for background.
- Label rule, 8-connectivity, pix_fg=1:
  - N≠0: label=N, no merge.
  - Else, among nonzero {W, NW, NE}: label = minimum of them.
  - merge_valid=1 only if NE≠0, (W|NW)≠0 and the two differ. merge_a=max, merge_b=min.
  - At most one merge per pixel.
- No neighbours: label=next_label; next_label increments; num_labels=next_label-1 after the update.
- Exhaustion: when next_label would exceed MAX_LABEL, new components get MAX_LABEL and overflow is set. It stays set until the next frame_start.
- Background pixel: label_out=0, merge_valid=0.
- Counters: x wraps at IMG_WIDTH-1 with y++ and row_valid=1. After pixel (IMG_WIDTH-1, IMG_HEIGHT-1), x=y=0 and row_valid=0.
- frame_start: on any accepted pixel, including mid-frame, that pixel is treated as (0,0). It resets next_label=1, overflow=0, num_labels=0 and row_valid=0. An aborted frame never produces frame_done.
- Reset mid-frame: reset takes priority. The output register clears the following cycle.

Optional Feature:
- CCL_4CONN_EN defined: 4-connectivity.
  - Only N and W are considered; label=min(nonzero N, W).
  - merge_valid when both are nonzero and differ.
  - NW and NE are unused.
- Undefined: 8-connectivity as specified in Behaviour.

Decomposition:
- ccl_pkg holds: label_t (LABEL_WIDTH vector), BG_LABEL=0, MAX_LABEL, min/max label functions, coordinate widths. The label merger shares ccl_pkg.
- Sub-module ccl_line_buffer: IMG_WIDTH x LABEL_WIDTH array, write at x, combinational reads at x and x+1. It supplies N/NE, with NW delayed in the labeler.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4 unless stated):
1. Reset with enable=1, no pixels → all outputs 0 indefinitely; first frame then starts at x=0, y=0.
2. Single fg pixel at (3,1) → label_out=1 at x=3,y=1; no merge_valid; num_labels=1; frame_done pulses with pixel (7,3).
3. U-shape: row0 fg at x=1,5; row1 fg at x=1..5 → row0 labels 1,2. Row1 x=1..4 label 1; x=4 asserts merge_valid with a=2, b=1; x=5 label 2.
4. Diagonal: row0 fg x=2, row1 fg x=3 → both label 1. With CCL_4CONN_EN, second pixel gets label 2 and no merge.
5. Overflow: LABEL_WIDTH=3, 9 isolated pixels → labels 1..7, then 7, 7; overflow=1. The next frame_start clears overflow and restarts labels at 1.
6. Gaps and restart: pix_valid/enable low for 3 cycles mid-row → x holds, no outputs. frame_start at (4,2) → that pixel is output as (0,0) with label 1, and no frame_done for the aborted frame.

Source files
------------

// File: rtl/ccl_pkg.sv
// ccl_pkg: label type, limits and label helpers shared by the labeler
// and the downstream label merger.
package ccl_pkg;

    localparam int CCL_IMG_WIDTH   = 320;
    localparam int CCL_IMG_HEIGHT  = 240;
    localparam int CCL_LABEL_WIDTH = 8;
    localparam int CCL_X_WIDTH     = $clog2(CCL_IMG_WIDTH);
    localparam int CCL_Y_WIDTH     = $clog2(CCL_IMG_HEIGHT);

    typedef logic [CCL_LABEL_WIDTH-1:0] label_t;

    localparam label_t BG_LABEL  = '0;
    localparam label_t MAX_LABEL = '1;

    function automatic label_t label_min(input label_t a, input label_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic label_t label_max(input label_t a, input label_t b);
        return (a > b) ? a : b;
    endfunction

    // Smallest of two labels, ignoring background.
    function automatic label_t label_nz_min(input label_t a, input label_t b);
        if (a == BG_LABEL) begin
            return b;
        end
        if (b == BG_LABEL) begin
            return a;
        end
        return label_min(a, b);
    endfunction

endpackage

// File: rtl/ccl_labeler_line_buffer.sv
// ccl_line_buffer: one row of previous-row labels, written at x,
// read combinationally at x (N) and x+1 (NE).
module ccl_line_buffer
    import ccl_pkg::*;
#(
    parameter int IMG_WIDTH   = CCL_IMG_WIDTH,
    parameter int LABEL_WIDTH = CCL_LABEL_WIDTH,
    localparam int XW         = $clog2(IMG_WIDTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [XW-1:0]          wr_addr,
    input  logic [LABEL_WIDTH-1:0] wr_data,
    input  logic [XW-1:0]          rd_addr,
    output logic [LABEL_WIDTH-1:0] rd_n,
    output logic [LABEL_WIDTH-1:0] rd_ne
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

    logic [LABEL_WIDTH-1:0] mem_q [IMG_WIDTH];
    logic [XW-1:0]          ne_addr;

    // The NE read at the last column is masked by the labeler.
    always_comb begin
        ne_addr = (rd_addr == X_LAST) ? '0 : rd_addr + 1'b1;
        rd_n    = mem_q[rd_addr];
        rd_ne   = mem_q[ne_addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/ccl_labeler.sv
// ccl_labeler: first-pass raster connected-component labeler.
// Define CCL_4CONN_EN for 4-connectivity; default is 8-connectivity.
module ccl_labeler
    import ccl_pkg::*;
#(
    parameter int IMG_WIDTH   = CCL_IMG_WIDTH,
    parameter int IMG_HEIGHT  = CCL_IMG_HEIGHT,
    parameter int LABEL_WIDTH = CCL_LABEL_WIDTH,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pix_valid,
    input  logic                   pix_fg,
    input  logic                   frame_start,
    output logic                   label_valid,
    output logic [LABEL_WIDTH-1:0] label_out,
    output logic [XW-1:0]          label_x,
    output logic [YW-1:0]          label_y,
    output logic                   merge_valid,
    output logic [LABEL_WIDTH-1:0] merge_a,
    output logic [LABEL_WIDTH-1:0] merge_b,
    output logic                   frame_done,
    output logic [LABEL_WIDTH-1:0] num_labels,
    output logic                   overflow
);

    localparam int LW = LABEL_WIDTH;
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [LW:0]   NEXT_ONE = (LW+1)'(1);
    localparam logic [LW:0]   NEXT_MAX = {1'b0, {LW{1'b1}}};
    localparam logic [LW-1:0] MAX_L    = {LW{1'b1}};

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic          row_valid_q, row_valid_d, row_valid_cur;
    logic [LW:0]   next_label_q, next_label_d, next_cur, next_nxt;
    logic [LW-1:0] w_q, w_d, nw_q, nw_d;

    logic          label_valid_q, label_valid_d;
    logic [LW-1:0] label_out_q, label_out_d;
    logic [XW-1:0] label_x_q, label_x_d;
    logic [YW-1:0] label_y_q, label_y_d;
    logic          merge_valid_q, merge_valid_d;
    logic [LW-1:0] merge_a_q, merge_a_d;
    logic [LW-1:0] merge_b_q, merge_b_d;
    logic          frame_done_q, frame_done_d;
    logic [LW-1:0] num_labels_q, num_labels_d;
    logic          overflow_q, overflow_d;

    logic          accept, first_col, last_col, last_row;
    logic          ovf_cur, ovf_nxt, mrg;
    logic [LW-1:0] n_raw, ne_raw;
    logic [LW-1:0] n_lbl, ne_lbl, nw_lbl, w_lbl;
    logic [LW-1:0] cand, lbl, mrg_a, mrg_b;
`ifdef CCL_4CONN_EN
    logic          unused_diag;
`else
    logic [LW-1:0] wn_lbl;
`endif

    ccl_line_buffer #(
        .IMG_WIDTH   (IMG_WIDTH),
        .LABEL_WIDTH (LABEL_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .we      (accept),
        .wr_addr (x_cur),
        .wr_data (lbl),
        .rd_addr (x_cur),
        .rd_n    (n_raw),
        .rd_ne   (ne_raw)
    );

    always_comb begin
        accept        = enable && pix_valid;
        // A frame_start pixel is processed as (0,0) of a fresh frame.
        x_cur         = frame_start ? '0 : x_q;
        y_cur         = frame_start ? '0 : y_q;
        row_valid_cur = frame_start ? 1'b0 : row_valid_q;
        next_cur      = frame_start ? NEXT_ONE : next_label_q;
        ovf_cur       = frame_start ? 1'b0 : overflow_q;
        first_col     = (x_cur == '0);
        last_col      = (x_cur == X_LAST);
        last_row      = (y_cur == Y_LAST);

        n_lbl  = row_valid_cur ? n_raw : '0;
        ne_lbl = (row_valid_cur && !last_col) ? ne_raw : '0;
        nw_lbl = (row_valid_cur && !first_col) ? nw_q : '0;
        w_lbl  = first_col ? '0 : w_q;

`ifdef CCL_4CONN_EN
        unused_diag = ^{ne_lbl, nw_lbl};
        cand  = LW'(label_nz_min(label_t'(n_lbl), label_t'(w_lbl)));
        mrg   = (n_lbl != '0) && (w_lbl != '0) && (n_lbl != w_lbl);
        mrg_a = LW'(label_max(label_t'(n_lbl), label_t'(w_lbl)));
        mrg_b = LW'(label_min(label_t'(n_lbl), label_t'(w_lbl)));
`else
        // W and NW are vertically adjacent, so they never disagree.
        wn_lbl = (w_lbl != '0) ? w_lbl : nw_lbl;
        if (n_lbl != '0) begin
            cand = n_lbl;
        end else begin
            cand = LW'(label_nz_min(label_t'(wn_lbl), label_t'(ne_lbl)));
        end
        mrg   = (n_lbl == '0) && (ne_lbl != '0) && (wn_lbl != '0)
                && (ne_lbl != wn_lbl);
        mrg_a = LW'(label_max(label_t'(ne_lbl), label_t'(wn_lbl)));
        mrg_b = LW'(label_min(label_t'(ne_lbl), label_t'(wn_lbl)));
`endif

        lbl      = '0;
        next_nxt = next_cur;
        ovf_nxt  = ovf_cur;
        if (pix_fg) begin
            if (cand != '0) begin
                lbl = cand;
            end else if (next_cur <= NEXT_MAX) begin
                lbl      = next_cur[LW-1:0];
                next_nxt = next_cur + 1'b1;
            end else begin
                lbl     = MAX_L;
                ovf_nxt = 1'b1;
            end
        end

        x_d           = x_q;
        y_d           = y_q;
        row_valid_d   = row_valid_q;
        next_label_d  = next_label_q;
        w_d           = w_q;
        nw_d          = nw_q;
        label_valid_d = 1'b0;
        label_out_d   = label_out_q;
        label_x_d     = label_x_q;
        label_y_d     = label_y_q;
        merge_valid_d = 1'b0;
        merge_a_d     = merge_a_q;
        merge_b_d     = merge_b_q;
        frame_done_d  = 1'b0;
        num_labels_d  = num_labels_q;
        overflow_d    = overflow_q;

        if (accept) begin
            x_d           = last_col ? '0 : x_cur + 1'b1;
            y_d           = last_col ? (last_row ? '0 : y_cur + 1'b1) : y_cur;
            row_valid_d   = last_col ? !last_row : row_valid_cur;
            next_label_d  = next_nxt;
            w_d           = lbl;
            nw_d          = n_raw;
            label_valid_d = 1'b1;
            label_out_d   = lbl;
            label_x_d     = x_cur;
            label_y_d     = y_cur;
            merge_valid_d = pix_fg && mrg;
            merge_a_d     = mrg_a;
            merge_b_d     = mrg_b;
            frame_done_d  = last_col && last_row;
            num_labels_d  = LW'(next_nxt - 1'b1);
            overflow_d    = ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            row_valid_q   <= 1'b0;
            next_label_q  <= NEXT_ONE;
            w_q           <= '0;
            nw_q          <= '0;
            label_valid_q <= 1'b0;
            label_out_q   <= '0;
            label_x_q     <= '0;
            label_y_q     <= '0;
            merge_valid_q <= 1'b0;
            merge_a_q     <= '0;
            merge_b_q     <= '0;
            frame_done_q  <= 1'b0;
            num_labels_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            row_valid_q   <= row_valid_d;
            next_label_q  <= next_label_d;
            w_q           <= w_d;
            nw_q          <= nw_d;
            label_valid_q <= label_valid_d;
            label_out_q   <= label_out_d;
            label_x_q     <= label_x_d;
            label_y_q     <= label_y_d;
            merge_valid_q <= merge_valid_d;
            merge_a_q     <= merge_a_d;
            merge_b_q     <= merge_b_d;
            frame_done_q  <= frame_done_d;
            num_labels_q  <= num_labels_d;
            overflow_q    <= overflow_d;
        end
    end

    assign label_valid = label_valid_q;
    assign label_out   = label_out_q;
    assign label_x     = label_x_q;
    assign label_y     = label_y_q;
    assign merge_valid = merge_valid_q;
    assign merge_a     = merge_a_q;
    assign merge_b     = merge_b_q;
    assign frame_done  = frame_done_q;
    assign num_labels  = num_labels_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ccl_labeler.sv
// tb_ccl_labeler: directed checks of ccl_labeler on an 8x4 frame plus a
// 20x2, 3-bit-label instance for label exhaustion.
module tb_ccl_labeler;

    logic       clk = 1'b0;
    logic       rst, enable, pix_valid, pix_fg, frame_start;
    logic       label_valid, merge_valid, frame_done, overflow;
    logic [7:0] label_out, merge_a, merge_b, num_labels;
    logic [2:0] label_x;
    logic [1:0] label_y;

    logic       o_valid, o_fg, o_fs;
    logic       o_lv, o_mv, o_done, o_ovf;
    logic [2:0] o_lab, o_ma, o_mb, o_num;
    logic [4:0] o_x;
    logic [0:0] o_y;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int scen;
        int x;
        int y;
        int lbl;
        bit mv;
        int ma;
        int mb;
    } vec_t;

    vec_t vecs[$];
    int   lab_c [4][8];
    bit   mv_c  [4][8];
    int   ma_c  [4][8];
    int   mb_c  [4][8];

    always #5 clk = ~clk;

    ccl_labeler #(
        .IMG_WIDTH   (8),
        .IMG_HEIGHT  (4),
        .LABEL_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pix_valid   (pix_valid),
        .pix_fg      (pix_fg),
        .frame_start (frame_start),
        .label_valid (label_valid),
        .label_out   (label_out),
        .label_x     (label_x),
        .label_y     (label_y),
        .merge_valid (merge_valid),
        .merge_a     (merge_a),
        .merge_b     (merge_b),
        .frame_done  (frame_done),
        .num_labels  (num_labels),
        .overflow    (overflow)
    );

    ccl_labeler #(
        .IMG_WIDTH   (20),
        .IMG_HEIGHT  (2),
        .LABEL_WIDTH (3)
    ) dut_ovf (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pix_valid   (o_valid),
        .pix_fg      (o_fg),
        .frame_start (o_fs),
        .label_valid (o_lv),
        .label_out   (o_lab),
        .label_x     (o_x),
        .label_y     (o_y),
        .merge_valid (o_mv),
        .merge_a     (o_ma),
        .merge_b     (o_mb),
        .frame_done  (o_done),
        .num_labels  (o_num),
        .overflow    (o_ovf)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int s, input int x, input int y,
                                input int l, input bit mv = 0,
                                input int a = 0, input int b = 0);
        vec_t v;
        v = '{s, x, y, l, mv, a, b};
        vecs.push_back(v);
    endfunction

    task automatic px(input bit v, input bit fg, input bit fs);
        pix_valid   = v;
        pix_fg      = fg;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] mask, input int exp_merges,
                             input string tag);
        int bad_xy   = 0;
        int bad_bg   = 0;
        int bad_done = 0;
        int merges   = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                px(1'b1, mask[y*8+x], (x == 0) && (y == 0));
                lab_c[y][x] = int'(label_out);
                mv_c[y][x]  = merge_valid;
                ma_c[y][x]  = int'(merge_a);
                mb_c[y][x]  = int'(merge_b);
                if (!label_valid || label_x != x[2:0] || label_y != y[1:0])
                    bad_xy++;
                if (!mask[y*8+x] && (label_out != 0 || merge_valid))
                    bad_bg++;
                if (frame_done != ((x == 7) && (y == 3)))
                    bad_done++;
                if (merge_valid)
                    merges++;
            end
        end
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        check({tag, "_coords"}, bad_xy, 0);
        check({tag, "_bg_zero"}, bad_bg, 0);
        check({tag, "_frame_done"}, bad_done, 0);
        check({tag, "_merges"}, merges, exp_merges);
    endtask

    task automatic check_vecs(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s) begin
                string nm;
                int    x, y;
                x  = vecs[i].x;
                y  = vecs[i].y;
                nm = $sformatf("s%0d_px%0d_%0d", s, x, y);
                check({nm, "_label"}, lab_c[y][x], vecs[i].lbl);
                check({nm, "_mv"}, mv_c[y][x], vecs[i].mv);
                if (vecs[i].mv)
                    check({nm, "_ab"}, ma_c[y][x] * 256 + mb_c[y][x],
                          vecs[i].ma * 256 + vecs[i].mb);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int done_cnt;
        int k;
        int exp;

        rst = 1'b1; enable = 1'b1;
        pix_valid = 1'b0; pix_fg = 1'b0; frame_start = 1'b0;
        o_valid = 1'b0; o_fg = 1'b0; o_fs = 1'b0;

        // scenario 0: single pixel
        add(0, 3, 1, 1);
        // scenario 1: U-shape
        add(1, 1, 0, 1);
        add(1, 5, 0, 2);
        add(1, 1, 1, 1);
        add(1, 2, 1, 1);
        add(1, 3, 1, 1);
`ifdef CCL_4CONN_EN
        add(1, 4, 1, 1);
        add(1, 5, 1, 1, 1, 2, 1);
`else
        add(1, 4, 1, 1, 1, 2, 1);
        add(1, 5, 1, 2);
`endif
        // scenario 2: diagonal
        add(2, 2, 0, 1);
`ifdef CCL_4CONN_EN
        add(2, 3, 1, 2);
`else
        add(2, 3, 1, 1);
`endif
        // scenario 3: row edges
        add(3, 0, 0, 1);
        add(3, 7, 1, 2);
        add(3, 0, 2, 3);
        add(3, 0, 3, 3);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {label_valid, label_out, label_x, label_y, merge_valid,
               merge_a[2:0], frame_done, num_labels[2:0], overflow}, 0);
        rst = 1'b0;

        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if ({label_valid, label_out, label_x, label_y, merge_valid,
                 merge_a, merge_b, frame_done, num_labels, overflow} != 0)
                bad++;
            if ({o_lv, o_lab, o_x, o_y, o_mv, o_done, o_num, o_ovf} != 0)
                bad++;
        end
        check("idle_outputs_zero", bad, 0);

        px(1'b1, 1'b1, 1'b0);
        check("first_pixel_xy", {label_y, label_x}, 0);
        check("first_pixel_valid", label_valid, 1);
        check("first_pixel_label", label_out, 1);

        run_frame(32'h0000_0800, 0, "single");
        check_vecs(0);
        check("single_num_labels", num_labels, 1);

        run_frame(32'h0000_3E22, 1, "ushape");
        check_vecs(1);
        check("ushape_num_labels", num_labels, 2);

        run_frame(32'h0000_0804, 0, "diag");
        check_vecs(2);
`ifdef CCL_4CONN_EN
        check("diag_num_labels", num_labels, 2);
`else
        check("diag_num_labels", num_labels, 1);
`endif

        run_frame(32'h0101_8001, 0, "edge");
        check_vecs(3);
        check("edge_num_labels", num_labels, 3);
        // frame wrapped: row 0 again, so N must not see (0,3)
        px(1'b1, 1'b1, 1'b0);
        check("wrap_xy", {label_y, label_x}, 0);
        check("wrap_label", label_out, 4);

        // gaps then a mid-frame restart
        for (int x = 0; x < 8; x++) px(1'b1, (x == 1) || (x == 5), x == 0);
        for (int x = 0; x < 10; x++) px(1'b1, 1'b0, 1'b0);
        bad = 0;
        enable = 1'b0;
        px(1'b1, 1'b1, 1'b0);
        if (label_valid || merge_valid) bad++;
        enable = 1'b1;
        px(1'b0, 1'b1, 1'b0);
        if (label_valid || merge_valid) bad++;
        px(1'b0, 1'b1, 1'b0);
        if (label_valid || merge_valid) bad++;
        check("gap_quiet", bad, 0);
        check("gap_hold_x", label_x, 1);
        px(1'b1, 1'b0, 1'b0);
        check("gap_resume_xy", {label_y, label_x}, {2'd2, 3'd2});
        px(1'b1, 1'b0, 1'b0);
        check("gap_num_labels", num_labels, 2);
        px(1'b1, 1'b1, 1'b1);
        check("restart_xy", {label_y, label_x}, 0);
        check("restart_label", label_out, 1);
        check("restart_num_labels", num_labels, 1);
        check("restart_no_done", frame_done, 0);
        done_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            px(1'b1, 1'b0, 1'b0);
            if (frame_done) done_cnt++;
        end
        check("restart_done_count", done_cnt, 1);
        check("restart_done_last", frame_done, 1);

        // reset in the middle of a frame
        px(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        px(1'b1, 1'b1, 1'b0);
        check("midrst_valid", label_valid, 0);
        check("midrst_num", num_labels, 0);
        rst = 1'b0;
        px(1'b1, 1'b0, 1'b0);
        check("midrst_restart_xy", {label_y, label_x}, 0);
        pix_valid = 1'b0;

        // label exhaustion on the 3-bit instance
        k = 0;
        for (int x = 0; x < 20; x++) begin
            o_valid = 1'b1;
            o_fg    = (x % 2 == 0) && (x <= 16);
            o_fs    = (x == 0);
            @(posedge clk);
            #1;
            if (o_fg) begin
                exp = (k < 7) ? k + 1 : 7;
                check($sformatf("ovf_label_%0d", k), o_lab, exp);
                k++;
            end
        end
        o_valid = 1'b0;
        check("ovf_sticky", o_ovf, 1);
        check("ovf_num_labels", o_num, 7);
        o_valid = 1'b1; o_fg = 1'b1; o_fs = 1'b1;
        @(posedge clk);
        #1;
        o_valid = 1'b0; o_fs = 1'b0;
        check("ovf_cleared", o_ovf, 0);
        check("ovf_restart_label", o_lab, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
